// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the shift engine and the memory-mapped port block above it.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_DIV_WIDTH  = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_shift_engine_if.sv
// Port-block <-> shift-engine bundle plus the serial pins; the engine takes the master side.
interface spi_shift_engine_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int DIV_WIDTH  = SPI_DIV_WIDTH
);
    logic [DIV_WIDTH-1:0]  divider;
    logic                  xfer_start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  xfer_complete;
    logic                  miso;
    logic                  mosi;
    logic                  sclk;

    modport master (
        input  divider, xfer_start, tx_data, miso,
        output rx_data, xfer_complete, mosi, sclk
    );

    modport slave (
        output divider, xfer_start, tx_data, miso,
        input  rx_data, xfer_complete, mosi, sclk
    );

endinterface

// File: rtl/spi_phase_timer.sv
// Loadable down-counter timing one sclk half-period; phase_done flags the last cycle of a phase.
module spi_phase_timer #(
    parameter int DIV_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic [DIV_WIDTH-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_phase_done
);
    logic [DIV_WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec && (r_count != '0))
            r_count <= r_count - DIV_WIDTH'(1);
    end

    assign o_phase_done = (r_count == '0);

endmodule

// File: rtl/spi_shift_engine.sv
// Mode-0, MSB-first SPI master shift engine: one byte out on mosi and one byte in from miso per start.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int DIV_WIDTH  = SPI_DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    spi_shift_engine_if.master bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    spi_state_t            r_state,   w_state;
    logic [DIV_WIDTH-1:0]  r_div_q,   w_div_q;
    logic [DATA_WIDTH-1:0] r_tx_sr,   w_tx_sr;
    logic [DATA_WIDTH-1:0] r_rx_sr,   w_rx_sr;
    logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data;
    logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt;
    logic                  r_sclk,    w_sclk;
    logic                  r_mosi,    w_mosi;
    logic                  r_cmpl,    w_cmpl;

    logic                  w_tmr_load;
    logic                  w_tmr_dec;
    logic                  w_phase_done;
    logic [DIV_WIDTH-1:0]  w_tmr_val;

    // The first phase is loaded straight from the divider input, since div_q is only written on that edge.
    assign w_tmr_val = (r_state == IDLE) ? bus.divider : r_div_q;

    spi_phase_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_tmr_load),
        .i_load_val   (w_tmr_val),
        .i_dec        (w_tmr_dec),
        .o_phase_done (w_phase_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_div_q   <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b1;
            r_cmpl    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_div_q   <= w_div_q;
            r_tx_sr   <= w_tx_sr;
            r_rx_sr   <= w_rx_sr;
            r_rx_data <= w_rx_data;
            r_bit_cnt <= w_bit_cnt;
            r_sclk    <= w_sclk;
            r_mosi    <= w_mosi;
            r_cmpl    <= w_cmpl;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_div_q    = r_div_q;
        w_tx_sr    = r_tx_sr;
        w_rx_sr    = r_rx_sr;
        w_rx_data  = r_rx_data;
        w_bit_cnt  = r_bit_cnt;
        w_sclk     = r_sclk;
        w_mosi     = r_mosi;
        w_cmpl     = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_dec  = 1'b0;

        case (r_state)
            IDLE: begin
                w_sclk = 1'b0;
                w_mosi = 1'b1;
                if (bus.xfer_start) begin
                    w_div_q    = bus.divider;
                    w_tx_sr    = bus.tx_data;
                    w_bit_cnt  = '0;
                    w_tmr_load = 1'b1;
                    w_mosi     = bus.tx_data[DATA_WIDTH-1];
                    w_state    = LOW;
                end
            end
            LOW: begin
                if (w_phase_done) begin
                    w_sclk     = 1'b1;
                    w_rx_sr    = {r_rx_sr[DATA_WIDTH-2:0], bus.miso};
                    w_tmr_load = 1'b1;
                    w_state    = HIGH;
                end else begin
                    w_tmr_dec  = 1'b1;
                end
            end
            HIGH: begin
                if (w_phase_done) begin
                    w_sclk     = 1'b0;
                    w_tmr_load = 1'b1;
                    if (r_bit_cnt == CNT_W'(DATA_WIDTH-1)) begin
                        w_rx_data = r_rx_sr;
                        w_cmpl    = 1'b1;
                        w_mosi    = 1'b1;
                        w_state   = DONE;
                    end else begin
                        w_bit_cnt = r_bit_cnt + CNT_W'(1);
                        w_tx_sr   = {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
                        w_mosi    = r_tx_sr[DATA_WIDTH-2];
                        w_state   = LOW;
                    end
                end else begin
                    w_tmr_dec  = 1'b1;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign bus.sclk          = r_sclk;
    assign bus.mosi          = r_mosi;
    assign bus.rx_data       = r_rx_data;
    assign bus.xfer_complete = r_cmpl;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: timeline model of each transfer checked every cycle, plus directed scenarios.
module tb_spi_shift_engine;
    import spi_pkg::*;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   rise_cnt = 0;
    logic [7:0] mosi_cap = 8'h00;
    int   miso_mode = 2;   // 0: const 0, 1: const 1, 2: loopback from mosi, 3: random
    logic miso_rnd = 1'b0;

    spi_shift_engine_if bus();

    spi_shift_engine dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    assign bus.miso = (miso_mode == 2) ? bus.mosi :
                      (miso_mode == 3) ? miso_rnd : (miso_mode == 1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        #1 miso_rnd = 1'($urandom);
    end

    initial forever begin
        @(posedge bus.sclk);
        mosi_cap = {mosi_cap[6:0], bus.mosi};
        rise_cnt = rise_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a transfer is a timeline of 16 half-periods of (d+1) cycles followed by one done cycle.
    bit         m_busy = 0;
    int         m_k = 0;
    int         m_d = 0;
    logic [7:0] m_tx = 8'h00;
    logic [7:0] m_rx_acc = 8'h00;
    logic [7:0] m_rx_prev = 8'h00;

    initial forever begin
        int half, ph, bi;
        @(negedge clk);
        if (rst) begin
            chk("rst_sclk", 32'(bus.sclk), 0);
            chk("rst_mosi", 32'(bus.mosi), 1);
            chk("rst_cmpl", 32'(bus.xfer_complete), 0);
            chk("rst_rx",   32'(bus.rx_data), 0);
            m_busy    = 0;
            m_rx_prev = 8'h00;
        end else if (m_busy && (m_k < 16 * (m_d + 1))) begin
            half = m_d + 1;
            ph   = m_k % (2 * half);
            bi   = m_k / (2 * half);
            chk("sclk",    32'(bus.sclk), 32'(ph >= half));
            chk("mosi",    32'(bus.mosi), 32'(m_tx[7-bi]));
            chk("cmpl",    32'(bus.xfer_complete), 0);
            chk("rx_hold", 32'(bus.rx_data), 32'(m_rx_prev));
            if (ph == half - 1)
                m_rx_acc = {m_rx_acc[6:0], bus.miso};
            m_k = m_k + 1;
        end else if (m_busy) begin
            chk("done_sclk", 32'(bus.sclk), 0);
            chk("done_cmpl", 32'(bus.xfer_complete), 1);
            chk("done_rx",   32'(bus.rx_data), 32'(m_rx_acc));
            m_rx_prev = m_rx_acc;
            m_busy    = 0;
        end else begin
            chk("idle_sclk", 32'(bus.sclk), 0);
            chk("idle_mosi", 32'(bus.mosi), 1);
            chk("idle_cmpl", 32'(bus.xfer_complete), 0);
            chk("idle_rx",   32'(bus.rx_data), 32'(m_rx_prev));
            if (bus.xfer_start === 1'b1) begin
                m_busy = 1;
                m_k    = 0;
                m_d    = int'(bus.divider);
                m_tx   = bus.tx_data;
            end
        end
        if (bus.xfer_complete === 1'b1)
            n_cmp = n_cmp + 1;
    end

    task automatic start_xfer(input logic [8:0] d, input logic [7:0] tx, output int s);
        @(posedge clk);
        #1;
        bus.divider    = d;
        bus.tx_data    = tx;
        bus.xfer_start = 1'b1;
        @(posedge clk);
        #1;
        bus.xfer_start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_cmpl(input int s, input int limit, output int lat);
        lat = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.xfer_complete === 1'b1) begin
                lat = cyc - s;
                break;
            end
        end
        if (lat < 0)
            $display("FAIL timeout: got no xfer_complete within %0d cycles, expected one", limit);
    endtask

    task automatic wait_rises(input int target, input int limit);
        for (int i = 0; i < limit && rise_cnt < target; i++)
            @(negedge clk);
        chk("rise_wait", 32'(rise_cnt >= target), 1);
    endtask

    initial begin
        int s, lat, base_c, base_r;
        logic [7:0] tx;
        logic [8:0] d;

        rst = 1'b1;
        bus.divider    = '0;
        bus.tx_data    = '0;
        bus.xfer_start = 1'b0;
        #2;
        chk("reset_sclk", 32'(bus.sclk), 0);
        chk("reset_mosi", 32'(bus.mosi), 1);
        chk("reset_cmpl", 32'(bus.xfer_complete), 0);
        chk("reset_rx",   32'(bus.rx_data), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // divider 0, loopback A5
        miso_mode = 2;
        base_c = n_cmp; base_r = rise_cnt;
        start_xfer(9'd0, 8'hA5, s);
        wait_cmpl(s, 40, lat);
        chk("a5_latency", 32'(lat), 16);
        chk("a5_rx",      32'(bus.rx_data), 32'h A5);
        chk("a5_rises",   32'(rise_cnt - base_r), 8);
        chk("a5_mosi",    32'(mosi_cap), 32'h A5);
        repeat (4) @(posedge clk);
        chk("a5_pulses",  32'(n_cmp - base_c), 1);

        // divider 3, miso held high
        miso_mode = 1;
        base_c = n_cmp;
        start_xfer(9'd3, 8'h3C, s);
        wait_cmpl(s, 100, lat);
        chk("3c_latency", 32'(lat), 64);
        chk("3c_rx",      32'(bus.rx_data), 32'h FF);
        chk("3c_mosi",    32'(mosi_cap), 32'h 3C);
        repeat (6) @(posedge clk);
        chk("3c_pulses",  32'(n_cmp - base_c), 1);

        // start pulse mid-transfer must be ignored
        miso_mode = 2;
        base_c = n_cmp;
        start_xfer(9'd1, 8'hF0, s);
        repeat (10) @(posedge clk);
        #1;
        bus.tx_data    = 8'h00;
        bus.xfer_start = 1'b1;
        @(posedge clk);
        #1 bus.xfer_start = 1'b0;
        wait_cmpl(s, 60, lat);
        chk("f0_latency", 32'(lat), 32);
        chk("f0_rx",      32'(bus.rx_data), 32'h F0);
        chk("f0_mosi",    32'(mosi_cap), 32'h F0);
        repeat (8) @(posedge clk);
        #1;
        chk("f0_pulses",  32'(n_cmp - base_c), 1);
        chk("f0_idle_sclk", 32'(bus.sclk), 0);
        chk("f0_idle_mosi", 32'(bus.mosi), 1);

        // divider change 1 -> 7 after bit 2 waits for the next transfer
        base_r = rise_cnt;
        start_xfer(9'd1, 8'h96, s);
        wait_rises(base_r + 3, 40);
        bus.divider = 9'd7;
        wait_cmpl(s, 60, lat);
        chk("divchg_latency", 32'(lat), 32);
        chk("divchg_rx",      32'(bus.rx_data), 32'h 96);
        start_xfer(9'd7, 8'h69, s);
        wait_cmpl(s, 200, lat);
        chk("div7_latency",   32'(lat), 128);
        chk("div7_rx",        32'(bus.rx_data), 32'h 69);

        // reset after 3 bits
        base_c = n_cmp; base_r = rise_cnt;
        start_xfer(9'd2, 8'hE7, s);
        wait_rises(base_r + 3, 60);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_sclk", 32'(bus.sclk), 0);
        chk("midrst_mosi", 32'(bus.mosi), 1);
        chk("midrst_rx",   32'(bus.rx_data), 0);
        chk("midrst_cmpl", 32'(bus.xfer_complete), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_pulses", 32'(n_cmp - base_c), 0);
        start_xfer(9'd0, 8'hC3, s);
        wait_cmpl(s, 40, lat);
        chk("postrst_latency", 32'(lat), 16);
        chk("postrst_rx",      32'(bus.rx_data), 32'h C3);

        // rx_data holds the previous byte until DONE
        start_xfer(9'd0, 8'h5A, s);
        wait_cmpl(s, 40, lat);
        chk("hold_prev_rx", 32'(bus.rx_data), 32'h 5A);
        miso_mode = 0;
        start_xfer(9'd1, 8'hFF, s);
        repeat (20) @(negedge clk);
        chk("hold_mid_rx",  32'(bus.rx_data), 32'h 5A);
        wait_cmpl(s, 60, lat);
        chk("hold_done_rx", 32'(bus.rx_data), 32'h 00);

        // largest divider
        miso_mode = 2;
        start_xfer(9'd511, 8'hB4, s);
        wait_cmpl(s, 8300, lat);
        chk("maxdiv_latency", 32'(lat), 8192);
        chk("maxdiv_rx",      32'(bus.rx_data), 32'h B4);

        // randomized transfers with stray starts and divider churn
        for (int n = 0; n < 24; n++) begin
            d  = 9'($urandom_range(0, 6));
            tx = 8'($urandom);
            miso_mode = int'($urandom_range(0, 3));
            start_xfer(d, tx, s);
            lat = -1;
            for (int i = 0; i < 16 * (int'(d) + 1) + 10; i++) begin
                @(posedge clk);
                #1;
                bus.xfer_start = ($urandom_range(0, 15) == 0);
                bus.tx_data    = 8'($urandom);
                bus.divider    = 9'($urandom_range(0, 511));
                @(negedge clk);
                if (bus.xfer_complete === 1'b1) begin
                    lat = cyc - s;
                    break;
                end
            end
            @(posedge clk);
            #1 bus.xfer_start = 1'b0;
            chk("rand_latency", 32'(lat), 32'(16 * (int'(d) + 1)));
            repeat (2) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
